// File: rtl/relu_job_scheduler_pkg.sv
// rtl/relu_job_scheduler_pkg.sv - shared types and constants for the ReLU job scheduler
package relu_job_scheduler_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int ADDR_W_DEF    = 10;
    localparam int RELU_PIPE_LAT = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/relu_job_scheduler_arbiter.sv
// rtl/relu_job_scheduler_arbiter.sv - two-way round-robin arbiter, pointer moves only on a grant
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] win
);

    logic ptr;

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (take && (win != 2'b00)) begin
            ptr <= ~win[1];
        end
    end

endmodule

// File: rtl/relu_job_scheduler.sv
// rtl/relu_job_scheduler.sv - round-robin sequencer streaming buffer jobs through a registered ReLU
module relu_job_scheduler
    import relu_job_scheduler_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_REQ = 2
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   src_base,
    input  logic [NUM_REQ*ADDR_W-1:0]   dst_base,
    input  logic [NUM_REQ*(ADDR_W+1)-1:0] job_len,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic                        busy,
    output logic [ADDR_W:0]             zero_cnt,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [DATA_W-1:0]           rd_data,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data
);

    state_t              state, state_nx;
    logic                owner;
    logic [1:0]          req_m;
    logic [1:0]          win;
    logic                take;
    logic                sel;
    logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
    logic [ADDR_W:0]     rem;
    logic [1:0]          drain_cnt;
    logic                v1;
    logic [ADDR_W-1:0]   a1;

    // In DONE the finishing requester is masked, so the other one can be granted
    // back-to-back while a still-high req of the finisher waits one IDLE cycle.
    always_comb begin
        req_m = req;
        if (state == S_DONE) begin
            req_m = req & ~idx_onehot(owner);
        end
    end

    assign take = ((state == S_IDLE) || (state == S_DONE)) && (win != 2'b00);
    assign sel  = win[1];

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req_m),
        .take (take),
        .win  (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (take) state_nx = S_RUN;
            end
            S_RUN: begin
                if (rem == '0)      state_nx = S_DONE;
                else if (rem == 1)  state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == 2'(RELU_PIPE_LAT - 1)) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = take ? S_RUN : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign rd_en   = (state == S_RUN) && (rem != '0);
    assign rd_addr = rd_ptr;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE) ? idx_onehot(owner) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            owner     <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            rem       <= '0;
            drain_cnt <= '0;
            zero_cnt  <= '0;
            v1        <= 1'b0;
            a1        <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            grant <= take ? win : 2'b00;
            if (take) begin
                owner    <= sel;
                rd_ptr   <= sel ? src_base[2*ADDR_W-1:ADDR_W] : src_base[ADDR_W-1:0];
                wr_ptr   <= sel ? dst_base[2*ADDR_W-1:ADDR_W] : dst_base[ADDR_W-1:0];
                rem      <= sel ? job_len[2*(ADDR_W+1)-1:ADDR_W+1] : job_len[ADDR_W:0];
                zero_cnt <= '0;
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
                rem    <= rem - 1'b1;
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;

            // Stage 1 carries the destination address alongside the returning read.
            v1    <= rd_en;
            a1    <= wr_ptr;
            wr_en <= v1;
            if (v1) begin
                wr_addr <= a1;
                wr_data <= rd_data[DATA_W-1] ? '0 : rd_data;
                if (rd_data[DATA_W-1]) zero_cnt <= zero_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_relu_job_scheduler.sv
// tb/tb_relu_job_scheduler.sv - scoreboard bench for relu_job_scheduler
module tb_relu_job_scheduler;

    localparam int AW = 10;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req = '0;
    logic [2*AW-1:0]   src_base = '0;
    logic [2*AW-1:0]   dst_base = '0;
    logic [2*AW+1:0]   job_len = '0;
    logic [1:0]        grant, done;
    logic              busy;
    logic [AW:0]       zero_cnt;
    logic              rd_en, wr_en;
    logic [AW-1:0]     rd_addr, wr_addr;
    logic [DW-1:0]     rd_data = '0;
    logic [DW-1:0]     wr_data;

    relu_job_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .src_base(src_base), .dst_base(dst_base),
        .job_len(job_len), .grant(grant), .done(done), .busy(busy), .zero_cnt(zero_cnt),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [1024];
    logic [7:0] ref_mem [1024];
    logic       init_en = 1'b0;

    always @(posedge clk) begin
        if (init_en) begin
            for (int a = 0; a < 1024; a++) mem[a] <= ref_mem[a];
        end else begin
            if (rd_en) rd_data <= mem[rd_addr];
            if (wr_en) mem[wr_addr] <= wr_data;
        end
    end

    typedef struct { int addr; logic [7:0] data; int c; } wr_t;
    typedef struct { logic [1:0] g; int c; } glog_t;

    int    jsrc [2], jdst [2], jlen [2];
    int    posted_cnt [2] = '{0, 0};
    int    granted_cnt [2] = '{0, 0};
    int    rd_q [$];
    wr_t   wr_q [$];
    glog_t glog [$];
    bit    active = 0;
    bit    rr_ptr = 0;
    int    exp_owner, exp_zc, exp_done_cyc;
    logic [1:0] snap = '0;

    function automatic logic [7:0] relu(input logic [7:0] x);
        return ($signed(x) < 0) ? 8'h00 : x;
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: predicts arbitration and builds the job's expected traffic at grant.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_q.delete();
                wr_q.delete();
                active = 0;
                rr_ptr = 0;
                for (int i = 0; i < 2; i++) granted_cnt[i] = posted_cnt[i];
            end else begin
                if (grant != 2'b00) begin
                    int g, len, zc;
                    g = (snap == 2'b11) ? int'(rr_ptr) : int'(snap[1]);
                    chk(snap != 2'b00 && !active && grant == (g ? 2'b10 : 2'b01),
                        "grant", grant, g ? 2 : 1);
                    rr_ptr = (g == 0);
                    granted_cnt[g]++;
                    glog.push_back('{grant, cyc});
                    len = jlen[g];
                    zc = 0;
                    for (int k = 0; k < len; k++) begin
                        int s, d;
                        logic [7:0] v;
                        s = (jsrc[g] + k) & 1023;
                        d = (jdst[g] + k) & 1023;
                        if ($signed(ref_mem[s]) < 0) zc++;
                        v = relu(ref_mem[s]);
                        ref_mem[d] = v;
                        rd_q.push_back(s);
                        wr_q.push_back('{d, v, cyc + 2 + k});
                    end
                    exp_owner = g;
                    exp_zc = zc;
                    exp_done_cyc = cyc + ((len == 0) ? 1 : len + 2);
                    active = 1;
                end
                chk(rd_en == (rd_q.size() != 0), "rd_en", rd_en, rd_q.size() != 0);
                if (rd_en && rd_q.size() != 0) begin
                    int a;
                    a = rd_q.pop_front();
                    chk(rd_addr == a, "rd_addr", rd_addr, a);
                end
                if (wr_en) begin
                    if (wr_q.size() == 0) begin
                        chk(0, "wr_unexpected", wr_addr, 0);
                    end else begin
                        wr_t e;
                        e = wr_q.pop_front();
                        chk(wr_addr == e.addr && cyc == e.c, "wr_addr", {wr_addr, 32'(cyc)},
                            {10'(e.addr), 32'(e.c)});
                        chk(wr_data == e.data, "wr_data", wr_data, e.data);
                    end
                end
                chk(busy == active, "busy", busy, active);
                if (done != 2'b00) begin
                    chk(active && done == (exp_owner ? 2'b10 : 2'b01) && cyc == exp_done_cyc
                        && rd_q.size() == 0 && wr_q.size() == 0,
                        "done", {done, 32'(cyc)}, {2'(exp_owner ? 2 : 1), 32'(exp_done_cyc)});
                    chk(zero_cnt == exp_zc, "zero_cnt", zero_cnt, exp_zc);
                    active = 0;
                end else if (active && cyc > exp_done_cyc) begin
                    chk(0, "done_missing", cyc, exp_done_cyc);
                    active = 0;
                end
            end
            for (int i = 0; i < 2; i++) snap[i] = (posted_cnt[i] != granted_cnt[i]);
        end
    end

    task automatic post(input int i, input int s, input int d, input int l);
        jsrc[i] = s & 1023;
        jdst[i] = d & 1023;
        jlen[i] = l;
        src_base[i*AW +: AW] = AW'(s);
        dst_base[i*AW +: AW] = AW'(d);
        job_len[i*(AW+1) +: AW+1] = (AW+1)'(l);
        req[i] = 1'b1;
        posted_cnt[i]++;
    endtask

    task automatic wait_done(input int i, output bit ok);
        ok = 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(posedge clk); #1;
            if (done[i]) ok = 1;
        end
        if (!ok) chk(0, "done_timeout", i, i);
    endtask

    task automatic run_req(input int i, input int n, input bit hold, input int flen);
        bit ok;
        for (int j = 0; j < n; j++) begin
            int s, d, l;
            if ($urandom_range(3, 0) == 0) begin
                s = $urandom_range(1023, 0);
                d = s;
            end else begin
                s = $urandom_range(400, 0);
                d = $urandom_range(900, 512);
            end
            l = (flen >= 0) ? flen : $urandom_range(40, 0);
            post(i, s, d, l);
            wait_done(i, ok);
            @(posedge clk); #1;
            if (j == n - 1 || (!hold && $urandom_range(1, 0) == 0)) begin
                req[i] = 1'b0;
                repeat ($urandom_range(4, 0)) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic sync_mem();
        init_en = 1'b1;
        @(posedge clk); #1;
        init_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) begin @(posedge clk); #1; end
        chk({grant, done, busy, zero_cnt, rd_en, wr_en, rd_addr, wr_addr, wr_data} == '0,
            "reset_outputs", {grant, done, busy, rd_en, wr_en}, 0);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int c0, n0;
        logic [7:0] exp1 [4];
        logic [7:0] orig [4];
        exp1 = '{8'h05, 8'h00, 8'h7F, 8'h00};

        for (int a = 0; a < 1024; a++) ref_mem[a] = 8'($urandom);
        ref_mem['h010] = 8'h05; ref_mem['h011] = 8'hF0;
        ref_mem['h012] = 8'h7F; ref_mem['h013] = 8'h80;
        sync_mem();

        // Directed 1: single job with mixed signs
        do_reset();
        c0 = cyc;
        post(0, 'h010, 'h100, 4);
        wait_done(0, ok);
        chk(cyc == c0 + 7, "t1_done_cycle", cyc - c0, 7);
        chk(zero_cnt == 2, "t1_zero_cnt", zero_cnt, 2);
        @(posedge clk); #1;
        req[0] = 1'b0;
        for (int k = 0; k < 4; k++) chk(mem['h100 + k] == exp1[k], "t1_mem", mem['h100 + k], exp1[k]);

        // Directed 2: both requesters held, back-to-back alternation
        do_reset();
        n0 = glog.size();
        c0 = cyc;
        fork
            run_req(0, 2, 1, 3);
            run_req(1, 2, 1, 3);
        join
        chk(glog.size() - n0 == 4, "t2_grant_count", glog.size() - n0, 4);
        if (glog.size() - n0 == 4) begin
            for (int k = 0; k < 4; k++)
                chk(glog[n0 + k].g == ((k % 2) ? 2'b10 : 2'b01), "t2_order", glog[n0 + k].g, (k % 2) ? 2 : 1);
            chk(glog[n0 + 1].c == c0 + 7, "t2_second_grant", glog[n0 + 1].c - c0, 7);
        end

        // Directed 3: zero-length job on requester 1
        do_reset();
        c0 = cyc;
        post(1, $urandom_range(1023, 0), $urandom_range(1023, 0), 0);
        wait_done(1, ok);
        chk(cyc == c0 + 2, "t3_done_cycle", cyc - c0, 2);
        chk(glog.size() > 0 && glog[glog.size() - 1].c == c0 + 1 && glog[glog.size() - 1].g == 2'b10,
            "t3_grant", glog[glog.size() - 1].c - c0, 1);
        @(posedge clk); #1;
        req[1] = 1'b0;

        // Directed 4: in-place job wrapping the top of the buffer
        do_reset();
        for (int k = 0; k < 4; k++) orig[k] = ref_mem[(1022 + k) & 1023];
        post(0, 'h3FE, 'h3FE, 4);
        wait_done(0, ok);
        @(posedge clk); #1;
        req[0] = 1'b0;
        for (int k = 0; k < 4; k++)
            chk(mem[(1022 + k) & 1023] == relu(orig[k]), "t4_inplace", mem[(1022 + k) & 1023], relu(orig[k]));

        // Directed 5: reset in cycle 4 of an 8-element job, then rerun
        do_reset();
        post(0, 'h020, 'h200, 8);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk({grant, done, busy, zero_cnt, rd_en, wr_en, rd_addr, wr_addr, wr_data} == '0,
            "t5_abort_outputs", {grant, done, busy, rd_en, wr_en}, 0);
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            chk(done == 2'b00 && busy == 1'b0, "t5_no_done", {done, busy}, 0);
        end
        post(0, 'h020, 'h200, 8);
        wait_done(0, ok);
        chk(ok, "t5_rerun_done", ok, 1);
        @(posedge clk); #1;
        req[0] = 1'b0;

        // Directed 6: req dropped and inputs changed mid-job
        do_reset();
        post(0, 'h050, 'h250, 6);
        repeat (3) begin @(posedge clk); #1; end
        req[0] = 1'b0;
        src_base[AW-1:0] = AW'($urandom);
        job_len[AW:0] = (AW+1)'($urandom_range(40, 1));
        wait_done(0, ok);
        chk(ok, "t6_done", ok, 1);

        // Random traffic from both requesters
        do_reset();
        fork
            run_req(0, 15, 0, -1);
            run_req(1, 15, 0, -1);
        join

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
